// File: rtl/iter_muldiv_unit_pkg.sv
// Shared encodings and operand decode helpers for the iterative RV32M/RV64M multiply/divide unit.
package muldiv_pkg;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } md_state_t;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_signed_a(input logic [2:0] op);
        return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
               (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] op);
        return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/iter_muldiv_unit_if.sv
// Request/response bundle between the execute stage and the iterative multiply/divide unit.
interface iter_muldiv_unit_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            kill;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output in_valid, op, rs1_data, rs2_data, kill, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, rs1_data, rs2_data, kill, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/iter_muldiv_unit_fixup.sv
// Combinational sign correction, divide-by-zero override and result-half select.
module iter_muldiv_fixup
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      op_i,
    input  logic            neg_a_i,
    input  logic            neg_b_i,
    input  logic            div_zero_i,
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    output logic [XLEN-1:0] result_o
);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;

    // hi_i/lo_i hold the product for multiplies and remainder/quotient for divides.
    always_comb begin
        prod = {hi_i, lo_i};
        if (neg_a_i ^ neg_b_i) prod = -prod;
        quo = lo_i;
        if (neg_a_i ^ neg_b_i) quo = -lo_i;
        if (div_zero_i) quo = '1;
        rem = neg_a_i ? -hi_i : hi_i;
        case (op_i)
            MD_MUL:                    result_o = prod[XLEN-1:0];
            MD_MULH, MD_MULHSU,
            MD_MULHU:                  result_o = prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:           result_o = quo;
            default:                   result_o = rem;
        endcase
    end
endmodule

// File: rtl/iter_muldiv_unit.sv
// Iterative radix-2 RV32M/RV64M multiply/divide unit with back-pressure and kill.
// Optional ITER_MULDIV_EARLY_OUT_EN: zero operands skip the iteration and finish in 2 cycles.
module iter_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int CNT_W = $clog2(XLEN) + 1
) (
    input logic              clk,
    input logic              reset,
    iter_muldiv_unit_if.slave bus
);
    md_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] res_q, res_d;
    logic [2:0]      op_q, op_d;
    logic            sa_q, sa_d, sb_q, sb_d, dz_q, dz_d;
    logic [XLEN-1:0] m_q, m_d, hi_q, hi_d, lo_q, lo_d;

    logic            sa_in, sb_in;
    logic [XLEN-1:0] a_mag_in, b_mag_in, fix_res;
    logic [XLEN:0]   mul_sum, div_shift, div_diff;

    always_comb begin
        sa_in    = is_signed_a(bus.op) & bus.rs1_data[XLEN-1];
        sb_in    = is_signed_b(bus.op) & bus.rs2_data[XLEN-1];
        a_mag_in = sa_in ? -bus.rs1_data : bus.rs1_data;
        b_mag_in = sb_in ? -bus.rs2_data : bus.rs2_data;
        // m_q is the multiplicand for multiplies and the divisor for divides.
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, m_q};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        op_d    = op_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        dz_d    = dz_q;
        m_d     = m_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                op_d    = bus.op;
                sa_d    = sa_in;
                sb_d    = sb_in;
                dz_d    = (bus.rs2_data == '0);
                hi_d    = '0;
                m_d     = is_div(bus.op) ? b_mag_in : a_mag_in;
                lo_d    = is_div(bus.op) ? a_mag_in : b_mag_in;
                cnt_d   = CNT_W'(XLEN);
                state_d = BUSY;
`ifdef ITER_MULDIV_EARLY_OUT_EN
                if (bus.rs1_data == '0 || bus.rs2_data == '0) begin
                    hi_d    = (is_div(bus.op) && bus.rs2_data == '0) ? a_mag_in : '0;
                    lo_d    = '0;
                    state_d = FIXUP;
                end
`endif
            end
            BUSY: begin
                if (is_div(op_q)) begin
                    hi_d = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
                    lo_d = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
                end else begin
                    hi_d = mul_sum[XLEN:1];
                    lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = FIXUP;
            end
            FIXUP: begin
                res_d   = fix_res;
                state_d = DONE;
            end
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.kill && state_q != IDLE) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    always_ff @(posedge clk) begin
        op_q <= op_d;
        sa_q <= sa_d;
        sb_q <= sb_d;
        dz_q <= dz_d;
        m_q  <= m_d;
        hi_q <= hi_d;
        lo_q <= lo_d;
    end

    iter_muldiv_fixup #(.XLEN(XLEN)) u_fixup (
        .op_i      (op_q),
        .neg_a_i   (sa_q),
        .neg_b_i   (sb_q),
        .div_zero_i(dz_q & is_div(op_q)),
        .hi_i      (hi_q),
        .lo_i      (lo_q),
        .result_o  (fix_res)
    );

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.result    = res_q;
endmodule

// File: doc/iter_muldiv_unit.md
Name: iter_muldiv_unit

Overview:
Parametrised, multi-cycle multiply/divide unit implementing the RV32M/RV64M operations, selected by the M-extension funct3. It sits beside the single-cycle ALU in the execute stage. It accepts one operation per valid/ready handshake, computes iteratively at one bit per cycle, and holds its result until the consumer takes it. It adds sequential arithmetic, back-pressure and abort, which the combinational ALU does not have.

Parameters:
XLEN, 32, operand/result width; legal values 32 or 64.
CNT_W, $clog2(XLEN)+1, iteration counter width; derived, not overridden.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operation request valid
in_ready  output  1  unit can accept a request (high only in IDLE)
op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1_data  input  XLEN  operand A (multiplicand / dividend)
rs2_data  input  XLEN  operand B (multiplier / divisor)
kill  input  1  abort the in-flight operation (pipeline flush)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  XLEN  operation result
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (sync, reset=1 at posedge): state=IDLE, in_ready=1, out_valid=0, result=0, busy=0, counter=0. Reset dominates kill and all handshakes.
- States: IDLE, BUSY, FIXUP, DONE.
- IDLE: in_ready=1. in_valid&in_ready at posedge -> latch op, operand magnitudes and sign flags; counter=XLEN; go to BUSY.
- BUSY: one radix-2 step per cycle; counter decrements. counter reaches 1 -> FIXUP.
  - Multiply: shift-add on a 2*XLEN accumulator.
  - Divide: restoring shift-subtract, producing quotient and remainder.
- FIXUP (1 cycle): apply sign correction, select the output half, register result; go to DONE.
- DONE: out_valid=1 and result stable. out_valid&out_ready -> IDLE. in_ready stays 0 until IDLE, so there is no accept in the same cycle as the result handshake.
- Latency: accept edge to out_valid high = XLEN+2 cycles (34 for XLEN=32). Throughput is one operation per XLEN+3 cycles minimum.
- Signedness:
  - MUL, MULH, DIV and REM treat both operands as signed.
  - MULHSU treats rs1 as signed and rs2 as unsigned.
  - MULHU, DIVU and REMU are unsigned.
  - Operands are converted to magnitudes on accept.
  - Product sign = sA^sB.
  - Quotient sign = sA^sB; remainder sign = sA.
- Result select: MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
- Divide by zero (rs2=0): quotient = all ones (signed and unsigned), remainder = rs1. Still takes the full latency.
- Signed overflow (rs1 = most-negative, rs2 = -1, DIV/REM): quotient = rs1, remainder = 0.
- kill: in BUSY, FIXUP or DONE -> IDLE next cycle, out_valid=0, no result delivered. kill in IDLE is ignored. kill and in_valid together in IDLE: the request is accepted (kill applies only to in-flight work).
- Inputs rs1_data, rs2_data and op are sampled only on the accept edge; later changes have no effect.

Optional Feature:
Macro ITER_MULDIV_EARLY_OUT_EN.
- Defined: on accept, if rs2=0 or rs1=0, skip BUSY and go straight to FIXUP. Latency becomes 2 cycles, and results are identical to the full path, including the div-by-zero rule.
- Undefined: every operation takes XLEN+2 cycles, giving fixed latency.

Decomposition:
- Shared package muldiv_pkg:
  - op encodings MD_MUL..MD_REMU
  - state encoding (IDLE=2'd0, BUSY=2'd1, FIXUP=2'd2, DONE=2'd3)
  - is_div / is_signed_a / is_signed_b decode helpers
- One sub-module: iter_muldiv_fixup. It is combinational and performs sign correction, special-case override and result-half select, so it can be unit-tested in isolation.

Test Plan:
- MUL rs1=7, rs2=-3 (0xFFFFFFFD) -> result 0xFFFFFFEB; out_valid exactly 34 cycles after accept.
- MULHU rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> 0xFFFFFFFE. MULH same operands -> 0x00000000. MULHSU same operands -> 0xFFFFFFFF.
- DIV rs1=-7, rs2=2 -> 0xFFFFFFFD (-3). REM rs1=-7, rs2=2 -> 0xFFFFFFFF (-1). DIVU rs1=-7 (0xFFFFFFF9), rs2=2 -> 0x7FFFFFFC.
- DIVU rs1=5, rs2=0 -> 0xFFFFFFFF. REM rs1=5, rs2=0 -> 5. DIV rs1=0x80000000, rs2=-1 -> 0x80000000; REM on the same operands -> 0.
- Hold out_ready=0 for 10 cycles in DONE -> out_valid and result stable, in_ready=0. Raise out_ready -> IDLE next cycle, in_ready=1.
- Assert kill at BUSY cycle 5 -> IDLE next cycle, out_valid never asserts. Then assert reset mid-BUSY on a fresh operation -> all outputs at reset values next cycle. With ITER_MULDIV_EARLY_OUT_EN defined, DIV by 0 -> out_valid 2 cycles after accept.
